// File: rtl/dtw_pkg.sv
// dtw_pkg: utterance geometry, stream cadence constants and controller state encoding
package dtw_pkg;
  localparam int FRAMES        = 40;
  localparam int FEATS         = 12;
  localparam int BYTES_PER_UTT = FRAMES * FEATS;
  localparam int FRAME_PERIOD  = FEATS + 1;
  localparam int SCORE_W       = 25;
  localparam logic [3:0] K_GAP         = 4'(FEATS);
  localparam logic [5:0] F_LAST        = 6'(FRAMES - 1);
  localparam logic [9:0] CNT_LAST_BYTE = 10'(BYTES_PER_UTT - 1);
  localparam logic [9:0] CNT_T_END     = 10'(FRAMES * FRAME_PERIOD + 2);
  typedef enum logic [3:0] {
    S_IDLE, S_CAPTURE, S_COPY, S_SEL, S_LOAD_T, S_LOAD_U, S_WAIT_SC, S_CMP, S_DONE
  } state_t;
endpackage

// File: rtl/dtw_frame_streamer.sv
// dtw_frame_streamer: walks the 12-bytes-plus-gap frame cadence one cycle ahead of the data
module dtw_frame_streamer
  import dtw_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_start,
  output logic [8:0] o_addr,
  output logic       o_gap,
  output logic       o_act,
  output logic       o_last
);
  logic       r_run;
  logic [5:0] r_f;
  logic [3:0] r_k;
  logic       w_end;
  assign o_act  = i_start | r_run;
  assign o_gap  = r_k == K_GAP;
  assign w_end  = r_f == F_LAST && o_gap;
  assign o_last = o_act && w_end;
  assign o_addr = o_gap ? 9'd0 : 9'(r_f) * 9'(FEATS) + 9'(r_k);
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_run <= 1'b0;
      r_f   <= '0;
      r_k   <= '0;
    end else if (o_act) begin
      r_run <= !w_end;
      r_f   <= w_end ? 6'd0 : r_f + 6'(o_gap);
      r_k   <= o_gap ? 4'd0 : r_k + 4'd1;
    end
  end
endmodule

// File: rtl/dtw_match_ctrl.sv
// dtw_match_ctrl: captures an utterance and either stores it as a template or scores it
// against every trained template through one shared scorer, reporting the best slot.
module dtw_match_ctrl
  import dtw_pkg::*;
#(
  parameter int NUM_WORDS = 4,
  parameter int WW        = $clog2(NUM_WORDS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               go,
  input  logic               train_mode,
  input  logic [WW-1:0]      word_sel,
  input  logic [7:0]         feat_in,
  input  logic               feat_valid,
  output logic               busy,
  output logic               done,
  output logic               match_valid,
  output logic [WW-1:0]      best_word,
  output logic [SCORE_W-1:0] best_score,
  output logic               sc_start,
  output logic               sc_train,
  output logic [7:0]         sc_in,
  input  logic [SCORE_W-1:0] sc_score,
  input  logic               sc_done
);
  localparam int TA_W = $clog2(NUM_WORDS * BYTES_PER_UTT);
  state_t               r_state, w_next;
  logic [9:0]           r_cnt, w_cnt_nxt;
  logic                 r_train, r_scored, r_match_valid, r_gap_q, r_act_q;
  logic [WW-1:0]        r_sel, r_run_word, r_best_word;
  logic [WW:0]          r_w, w_hit;
  logic [NUM_WORDS-1:0] r_slot_valid;
  logic [SCORE_W-1:0]   r_run_score, r_best_score;
  logic [7:0]           r_utt [BYTES_PER_UTT];
  logic [7:0]           r_tmpl [NUM_WORDS * BYTES_PER_UTT];
  logic [7:0]           r_utt_q, r_tmpl_q;
  logic                 w_found, w_gap, w_act, w_last;
  logic [8:0]           w_addr, w_off;
  logic [WW-1:0]        w_slot;
  logic [TA_W-1:0]      w_ta;

  dtw_frame_streamer u_stream (
    .clock   (clock),
    .reset   (reset),
    .i_start (sc_start),
    .o_addr  (w_addr),
    .o_gap   (w_gap),
    .o_act   (w_act),
    .o_last  (w_last)
  );

  assign busy        = r_state != S_IDLE && r_state != S_DONE;
  assign done        = r_state == S_DONE;
  assign sc_start    = (r_state == S_LOAD_T || r_state == S_LOAD_U) && r_cnt == 10'd0;
  assign sc_train    = r_state == S_LOAD_T;
  assign sc_in       = (r_act_q && !r_gap_q) ? (sc_train ? r_tmpl_q : r_utt_q) : 8'd0;
  assign match_valid = r_match_valid;
  assign best_word   = r_best_word;
  assign best_score  = r_best_score;
  assign w_slot      = r_state == S_COPY ? r_sel : r_w[WW-1:0];
  assign w_off       = r_state == S_COPY ? r_cnt[8:0] : w_addr;
  assign w_ta        = TA_W'(w_slot) * TA_W'(BYTES_PER_UTT) + TA_W'(w_off);

  always_comb begin
    w_found = 1'b0;
    w_hit   = r_w;
    for (int i = NUM_WORDS - 1; i >= 0; i--)
      if (r_slot_valid[i] && (WW+1)'(i) >= r_w) begin
        w_found = 1'b1;
        w_hit   = (WW+1)'(i);
      end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = go ? S_CAPTURE : S_IDLE;
      S_CAPTURE: if (feat_valid && r_cnt == CNT_LAST_BYTE) w_next = r_train ? S_COPY : S_SEL;
      S_COPY:    if (r_cnt == CNT_LAST_BYTE) w_next = S_DONE;
      S_SEL:     w_next = w_found ? S_LOAD_T : S_DONE;
      S_LOAD_T:  if (r_cnt == CNT_T_END) w_next = S_LOAD_U;
      S_LOAD_U:  if (w_last) w_next = S_WAIT_SC;
      S_WAIT_SC: if (sc_done && r_cnt >= 10'd2) w_next = S_CMP;
      S_CMP:     w_next = S_SEL;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // The counter keeps running from LOAD_U into WAIT_SC so it measures time since the scoring start.
  assign w_cnt_nxt = (w_next != r_state && w_next != S_WAIT_SC) ? 10'd0 :
                     r_cnt + (r_state == S_CAPTURE ? {9'd0, feat_valid} : {9'd0, ~&r_cnt});

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_train       <= 1'b0;
      r_sel         <= '0;
      r_w           <= '0;
      r_slot_valid  <= '0;
      r_run_score   <= '1;
      r_run_word    <= '0;
      r_scored      <= 1'b0;
      r_best_score  <= '1;
      r_best_word   <= '0;
      r_match_valid <= 1'b0;
      r_gap_q       <= 1'b0;
      r_act_q       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_gap_q <= w_gap;
      r_act_q <= w_act;
      if (r_state == S_IDLE && go) begin
        r_train     <= train_mode;
        r_sel       <= word_sel;
        r_w         <= '0;
        r_run_score <= '1;
        r_run_word  <= '0;
        r_scored    <= 1'b0;
      end
      if (r_state == S_COPY && w_next == S_DONE) r_slot_valid[r_sel] <= 1'b1;
      if (r_state == S_SEL && w_found) r_w <= w_hit;
      if (r_state == S_CMP) begin
        r_w      <= r_w + (WW+1)'(1);
        r_scored <= 1'b1;
        if (sc_score < r_run_score) begin
          r_run_score <= sc_score;
          r_run_word  <= r_w[WW-1:0];
        end
      end
      if (w_next == S_DONE && r_state != S_DONE) begin
        r_best_score  <= r_run_score;
        r_best_word   <= r_run_word;
        r_match_valid <= r_scored;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (r_state == S_CAPTURE && feat_valid) r_utt[r_cnt[8:0]] <= feat_in;
    r_utt_q <= r_utt[w_addr];
  end

  always_ff @(posedge clock) begin
    if (r_state == S_COPY) r_tmpl[w_ta] <= r_utt[r_cnt[8:0]];
    r_tmpl_q <= r_tmpl[w_ta];
  end
endmodule

// File: tb/tb_dtw_match_ctrl.sv
// tb_dtw_match_ctrl: directed vectors against a behavioural scorer (sum of squared byte differences)
module tb_dtw_match_ctrl;
  localparam logic [24:0] ONES = 25'h1FFFFFF;
  logic        clock = 1'b0, reset = 1'b0, go = 1'b0, train_mode = 1'b0, feat_valid = 1'b0;
  logic [1:0]  word_sel = '0, best_word;
  logic [7:0]  feat_in = '0, sc_in;
  logic        busy, done, match_valid, sc_start, sc_train;
  logic [24:0] best_score, sc_score = '0;
  logic        sc_done = 1'b0;
  int          n_checks = 0, n_errors = 0;

  dtw_match_ctrl dut (
    .clock(clock), .reset(reset), .go(go), .train_mode(train_mode), .word_sel(word_sel),
    .feat_in(feat_in), .feat_valid(feat_valid), .busy(busy), .done(done),
    .match_valid(match_valid), .best_word(best_word), .best_score(best_score),
    .sc_start(sc_start), .sc_train(sc_train), .sc_in(sc_in), .sc_score(sc_score),
    .sc_done(sc_done)
  );

  always #5 clock = ~clock;

  int          n_starts = 0, gap_err = 0, train_err = 0, m_c = 0, m_lat = 0;
  logic        m_run = 1'b0, m_train = 1'b0, m_prev_train = 1'b0;
  longint      m_acc = 0;
  logic [7:0]  m_tmpl [480];
  int          m_k, m_idx, m_d;
  logic        m_bad, m_gap_bad;
  assign m_k       = m_c % 13;
  assign m_idx     = (m_c / 13) * 12 + m_k;
  assign m_d       = int'(sc_in) - int'(m_tmpl[m_idx]);
  assign m_bad     = (sc_train && !busy) || (sc_start && !sc_train && !m_prev_train) ||
                     (m_run && !sc_start && sc_train != m_train);
  assign m_gap_bad = m_run && !sc_start && m_k == 12 && sc_in != 8'd0;

  always @(posedge clock) begin
    train_err <= train_err + int'(m_bad);
    gap_err   <= gap_err + int'(m_gap_bad);
    if (sc_start) begin
      n_starts     <= n_starts + 1;
      m_prev_train <= sc_train;
      m_run        <= 1'b1;
      m_c          <= 0;
      m_train      <= sc_train;
      m_acc        <= 0;
      m_lat        <= 0;
      if (!sc_train) sc_done <= 1'b0;
    end else if (m_run) begin
      if (m_k < 12) begin
        if (m_train) m_tmpl[m_idx] <= sc_in;
        else m_acc <= m_acc + longint'(m_d * m_d);
      end
      if (m_c == 519) begin
        m_run <= 1'b0;
        m_lat <= m_train ? 0 : 20;
      end
      m_c <= m_c + 1;
    end else if (m_lat > 0) begin
      m_lat <= m_lat - 1;
      if (m_lat == 1) begin
        sc_done  <= 1'b1;
        sc_score <= 25'(m_acc);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pbyte(input int pat, input int val, input int n);
    return pat == 1 ? 8'(n % 7) : pat == 2 ? 8'(n % 5) : 8'(val);
  endfunction

  task automatic do_reset();
    @(negedge clock) reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_op(input logic tm, input logic [1:0] ws, input int pat, input int val,
                        input bit abort, output bit got, output int lat, output logic mv,
                        output logic [1:0] bw, output logic [24:0] bs, output int starts);
    int s0, n, j;
    s0 = n_starts; mv = 1'bx; bw = 'x; bs = 'x;
    @(negedge clock); feat_valid = 1'b1; feat_in = 8'hAA;
    @(negedge clock); feat_valid = 1'b0; go = 1'b1; train_mode = tm; word_sel = ws;
    @(negedge clock); go = 1'b0;
    chk("busy_after_go", longint'(busy), 1);
    n = 0; j = 0;
    while (n < 480) begin
      feat_valid = (j % 50 != 49);
      feat_in    = feat_valid ? pbyte(pat, val, n) : 8'h77;
      go         = (j == 100);
      train_mode = (j == 100) ? ~tm : tm;
      word_sel   = (j == 100) ? ws + 2'd1 : ws;
      @(negedge clock);
      if (feat_valid) n++;
      j++;
    end
    feat_valid = 1'b0; go = 1'b0; train_mode = tm; word_sel = ws;
    got = 1'b0; lat = 0;
    if (abort) begin
      while (lat < 5000 && !got) begin
        if (sc_start && !sc_train) got = 1'b1;
        else begin @(negedge clock); lat++; end
      end
      repeat (100) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("abort_busy", longint'(busy), 0);
      chk("abort_sc_start", longint'(sc_start), 0);
      chk("abort_sc_in", longint'(sc_in), 0);
      chk("abort_sc_train", longint'(sc_train), 0);
      reset = 1'b1;
    end else begin
      while (lat < 20000 && !got) begin
        if (done) got = 1'b1;
        else begin @(negedge clock); lat++; end
      end
      mv = match_valid; bw = best_word; bs = best_score;
      @(negedge clock);
      chk("busy_after_done", longint'(busy), 0);
      chk("done_one_cycle", longint'(done), 0);
    end
    starts = n_starts - s0;
  endtask

  typedef struct {
    logic rst; logic tm; logic [1:0] ws; int pat; int val;
    logic mv; logic [1:0] bw; logic [24:0] bs; int starts; int maxlat;
  } vec_t;
  vec_t vt [12];

  initial begin
    bit got;
    int lat, starts;
    logic mv;
    logic [1:0] bw;
    logic [24:0] bs;
    vt[0]  = '{1'b1, 1'b1, 2'd2, 0, 5,  1'b0, 2'd0, ONES,     0, 0};
    vt[1]  = '{1'b0, 1'b0, 2'd0, 0, 5,  1'b1, 2'd2, 25'd0,    2, 0};
    vt[2]  = '{1'b1, 1'b0, 2'd0, 0, 9,  1'b0, 2'd0, ONES,     0, 4};
    vt[3]  = '{1'b0, 1'b1, 2'd0, 0, 0,  1'b0, 2'd0, ONES,     0, 0};
    vt[4]  = '{1'b0, 1'b1, 2'd1, 0, 10, 1'b0, 2'd0, ONES,     0, 0};
    vt[5]  = '{1'b0, 1'b1, 2'd3, 0, 20, 1'b0, 2'd0, ONES,     0, 0};
    vt[6]  = '{1'b0, 1'b0, 2'd0, 0, 9,  1'b1, 2'd1, 25'd480,  6, 0};
    vt[7]  = '{1'b1, 1'b1, 2'd0, 0, 3,  1'b0, 2'd0, ONES,     0, 0};
    vt[8]  = '{1'b0, 1'b1, 2'd1, 0, 3,  1'b0, 2'd0, ONES,     0, 0};
    vt[9]  = '{1'b0, 1'b0, 2'd0, 0, 5,  1'b1, 2'd0, 25'd1920, 4, 0};
    vt[10] = '{1'b1, 1'b1, 2'd3, 1, 0,  1'b0, 2'd0, ONES,     0, 0};
    vt[11] = '{1'b0, 1'b0, 2'd0, 2, 0,  1'b1, 2'd3, 25'd3344, 2, 0};
    repeat (3) @(negedge clock);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_match_valid", longint'(match_valid), 0);
    chk("rst_best_word", longint'(best_word), 0);
    chk("rst_best_score", longint'(best_score), longint'(ONES));
    chk("rst_sc_start", longint'(sc_start), 0);
    chk("rst_sc_train", longint'(sc_train), 0);
    chk("rst_sc_in", longint'(sc_in), 0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (vt[i].rst) do_reset();
      run_op(vt[i].tm, vt[i].ws, vt[i].pat, vt[i].val, 1'b0, got, lat, mv, bw, bs, starts);
      chk($sformatf("v%0d_done_seen", i), longint'(got), 1);
      chk($sformatf("v%0d_match_valid", i), longint'(mv), longint'(vt[i].mv));
      chk($sformatf("v%0d_best_word", i), longint'(bw), longint'(vt[i].bw));
      chk($sformatf("v%0d_best_score", i), longint'(bs), longint'(vt[i].bs));
      chk($sformatf("v%0d_sc_starts", i), longint'(starts), longint'(vt[i].starts));
      if (vt[i].maxlat != 0)
        chk($sformatf("v%0d_done_within_%0d", i, vt[i].maxlat), longint'(lat <= vt[i].maxlat), 1);
    end
    do_reset();
    run_op(1'b1, 2'd1, 0, 10, 1'b0, got, lat, mv, bw, bs, starts);
    chk("pre_abort_train_done", longint'(got), 1);
    run_op(1'b0, 2'd0, 0, 9, 1'b1, got, lat, mv, bw, bs, starts);
    chk("abort_reached_load_u", longint'(got), 1);
    run_op(1'b0, 2'd0, 0, 9, 1'b0, got, lat, mv, bw, bs, starts);
    chk("post_abort_done", longint'(got), 1);
    chk("post_abort_match_valid", longint'(mv), 0);
    chk("post_abort_best_score", longint'(bs), longint'(ONES));
    chk("post_abort_sc_starts", longint'(starts), 0);
    run_op(1'b1, 2'd1, 0, 10, 1'b0, got, lat, mv, bw, bs, starts);
    chk("retrain_done", longint'(got), 1);
    run_op(1'b0, 2'd0, 0, 9, 1'b0, got, lat, mv, bw, bs, starts);
    chk("rerun_match_valid", longint'(mv), 1);
    chk("rerun_best_word", longint'(bw), 1);
    chk("rerun_best_score", longint'(bs), 480);
    chk("rerun_sc_starts", longint'(starts), 2);
    @(negedge clock);
    chk("gap_bytes_nonzero", longint'(gap_err), 0);
    chk("sc_train_misuse", longint'(train_err), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
